// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the receiver, the program loader
//               and any future transmitter: receiver state encoding, frame
//               data width, default line settings and a baud divisor helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int DEFAULT_CLK_HZ     = 100_000_000;
    localparam int DEFAULT_BAUD       = 115_200;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Clock cycles per oversample tick, truncated.
    function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
// Module      : baud_tick_gen
// Description : Divisor counter producing a one-cycle tick every DIV clocks.
//               While clear is high the counter is held at zero and no tick
//               is emitted, so the first tick after clear drops arrives
//               exactly DIV clocks later.
// Ports       : clk   - system clock
//               rst   - asynchronous active-low reset
//               clear - hold counter at zero, suppress tick
//               tick  - one-cycle pulse when the counter reaches DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// ============================================================================
// Module      : uart_byte_rx
// Description : Oversampling UART byte receiver (8N1, or 8E1 when the macro
//               UART_RX_PARITY_EN is defined). Synchronises rx, validates the
//               start bit at mid-bit, samples data/parity/stop at mid-bit and
//               presents bytes on a one-deep valid/ready holding register.
// Ports       : clk        - system clock
//               rst        - asynchronous active-low reset
//               rx         - raw serial input, idle high
//               data       - received byte, valid while valid=1
//               valid      - holding register full
//               ready      - consumer takes data when valid && ready
//               frame_err  - one-cycle pulse, stop bit sampled low
//               overrun    - one-cycle pulse, byte dropped (register full)
//               parity_err - one-cycle pulse, even-parity mismatch
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      parity_err
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(UART_DATA_BITS);

    // Start validation fires on the (OVERSAMPLE/2-1)th tick; the counter
    // reaches OVERSAMPLE/2-2 after the preceding tick.
    localparam logic [SCW-1:0] HALF_LAST = SCW'(OVERSAMPLE / 2 - 2);
    localparam logic [SCW-1:0] BIT_LAST  = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] DBIT_LAST = BCW'(UART_DATA_BITS - 1);

    rx_state_e                 state;
    logic                      rx_meta;
    logic                      rx_sync;
    logic                      tick;
    logic [SCW-1:0]            sample_cnt;
    logic [BCW-1:0]            bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Held in reset while idle so each frame's tick phase starts from the
    // detected start edge.
    baud_tick_gen #(
        .DIV   (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic parity_err_r;
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            // Drain first; a delivery later in this block overrides it.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state      <= ST_START;
                        sample_cnt <= '0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (sample_cnt == HALF_LAST) begin
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            state      <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (sample_cnt == BIT_LAST) begin
                            sample_cnt <= '0;
                            shift      <= {rx_sync, shift[UART_DATA_BITS-1:1]};
                            if (bit_cnt == DBIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        if (sample_cnt == BIT_LAST) begin
                            sample_cnt <= '0;
                            par_bad    <= (rx_sync != ^shift);
                            state      <= ST_STOP;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
`endif

                ST_STOP: begin
                    if (tick) begin
                        if (sample_cnt == BIT_LAST) begin
                            sample_cnt <= '0;
                            if (!rx_sync) begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end else begin
                                state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                                if (par_bad) begin
                                    parity_err_r <= 1'b1;
                                end else
`endif
                                if (valid && !ready) begin
                                    overrun <= 1'b1;
                                end else begin
                                    data  <= shift;
                                    valid <= 1'b1;
                                end
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end

                // A line held low after a framing error reports once only.
                ST_BREAK: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
